rr_req_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 19 +
 rtl/onehot_dec2to4.sv | 22 ++
 rtl/rr_req_arbiter.sv | 116 +++++++++++
 tb/tb_rr_req_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin request arbiter.
// Holds the state encoding and the pointer rotation helper.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  // The index is exactly IDX_W bits wide, so 3 -> 0 wraps on its own.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/onehot_dec2to4.sv
// Combinational 2-bit index to 4-bit one-hot decoder, MSB-first
// (index 0 drives bit 3). The output is all-zero while en is low.
module onehot_dec2to4 (
  input  logic [1:0] idx,
  input  logic       en,
  output logic [3:0] onehot
);

  always_comb begin
    // NOTE: assign a default first so no path leaves onehot unassigned (no latch).
    onehot = 4'b0000;
    if (en) begin
      case (idx)
        2'b00:   onehot = 4'b1000;
        2'b01:   onehot = 4'b0100;
        2'b10:   onehot = 4'b0010;
        default: onehot = 4'b0001;
      endcase
    end
  end

endmodule

// File: rtl/rr_req_arbiter.sv
// Four-way round-robin arbiter with a registered grant index and one-hot decode.
// Define ARB_PREEMPT_EN to force release after HOLD_MAX cycles while others wait.
module rr_req_arbiter
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic                 gnt_valid,
  output logic                 busy
);

  if (HOLD_MAX < 2 || HOLD_MAX > 255 || (2 ** CNT_W) <= HOLD_MAX) begin : g_bad_cfg
    $error("rr_req_arbiter: HOLD_MAX must be 2..255 and fit in CNT_W bits");
  end

  arb_state_t          state;
  logic [IDX_W-1:0]    ptr;
  logic [NUM_REQ-1:0]  req_k;
  logic                pick_ok;
  logic [IDX_W-1:0]    pick_idx;
  logic                owner_req;

  // Requester k lives on req[NUM_REQ-1-k]; reorder so req_k[k] belongs to requester k.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      req_k[k] = req[NUM_REQ-1-k];
    end
  end

  // Scan offsets from largest to smallest so the request closest to ptr wins.
  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_k[ptr + IDX_W'(i)]) begin
        pick_ok  = 1'b1;
        pick_idx = ptr + IDX_W'(i);
      end
    end
  end

  onehot_dec2to4 u_dec (
    .idx    (gnt_idx),
    .en     (gnt_valid),
    .onehot (gnt)
  );

  // gnt shares req's bit ordering, so masking with it isolates the owner.
  assign owner_req = |(req & gnt);

`ifdef ARB_PREEMPT_EN
  logic [CNT_W-1:0] hold_cnt;
  logic             others_req;

  assign others_req = |(req & ~gnt);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      busy      <= 1'b0;
      ptr       <= '0;
`ifdef ARB_PREEMPT_EN
      hold_cnt  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      case (state)
        IDLE: begin
          if (pick_ok) begin
            state     <= GRANT;
            gnt_idx   <= pick_idx;
            gnt_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        GRANT: begin
          if (!owner_req) begin
            state     <= RELEASE;
            gnt_valid <= 1'b0;
          end
`ifdef ARB_PREEMPT_EN
          else if (hold_cnt == CNT_W'(HOLD_MAX - 1) && others_req) begin
            state     <= RELEASE;
            gnt_valid <= 1'b0;
          end else if (hold_cnt != {CNT_W{1'b1}}) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
`endif
        end
        RELEASE: begin
          state <= IDLE;
          busy  <= 1'b0;
          ptr   <= next_idx(gnt_idx);
`ifdef ARB_PREEMPT_EN
          hold_cnt <= '0;
`endif
        end
        default: begin
          state     <= IDLE;
          gnt_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Directed bench for rr_req_arbiter: reset, single grant, rotation, wrap,
// asynchronous reset mid-grant and the hold/preemption behaviour.
module tb_rr_req_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rr_req_arbiter #(.HOLD_MAX(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .busy      (busy)
  );

  function automatic logic [3:0] oh(input int k);
    logic [3:0] top_bit;
    top_bit = 4'b1000;
    return top_bit >> k;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = 4'b0000;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    req   = 4'b0000;
    rst_n = 1'b0;
    #2;
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_cmp++; if (gnt_idx !== 2'b00) begin n_bad++; $display("FAIL reset_idx: got %b want 00", gnt_idx); end
    n_cmp++; if (gnt_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", gnt_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    step();
    rst_n = 1'b1;
    repeat (3) step();
    n_cmp++; if (gnt_valid !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b0)
      begin n_bad++; $display("FAIL idle_no_req: valid=%b gnt=%b busy=%b want 0/0000/0", gnt_valid, gnt, busy); end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0010;
    step();
    n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL single_gnt: got %b want 0010", gnt); end
    n_cmp++; if (gnt_idx !== 2'b10) begin n_bad++; $display("FAIL single_idx: got %b want 10", gnt_idx); end
    n_cmp++; if (gnt_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", gnt_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy); end
    req = 4'b0000;
    step();
    n_cmp++; if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || busy !== 1'b1)
      begin n_bad++; $display("FAIL single_release: gnt=%b valid=%b busy=%b want 0000/0/1", gnt, gnt_valid, busy); end
    step();
    n_cmp++; if (gnt_valid !== 1'b0 || busy !== 1'b0)
      begin n_bad++; $display("FAIL single_idle: valid=%b busy=%b want 0/0", gnt_valid, busy); end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    req = 4'b1111;
    step();
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 3; c++) begin
        n_cmp++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 2'(order[g]) || gnt !== oh(order[g])) begin
          n_bad++;
          $display("FAIL rr_grant g=%0d c=%0d: valid=%b idx=%0d gnt=%b want 1/%0d/%b",
                   g, c, gnt_valid, gnt_idx, gnt, order[g], oh(order[g]));
        end
        if (c == 2) req = 4'b1111 & ~oh(order[g]);
        step();
      end
      n_cmp++; if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || busy !== 1'b1)
        begin n_bad++; $display("FAIL rr_release g=%0d: gnt=%b valid=%b busy=%b want 0000/0/1", g, gnt, gnt_valid, busy); end
      req = 4'b1111;
      step();
      n_cmp++; if (gnt_valid !== 1'b0 || busy !== 1'b0)
        begin n_bad++; $display("FAIL rr_idle g=%0d: valid=%b busy=%b want 0/0", g, gnt_valid, busy); end
      step();
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b0001;
    step();
    n_cmp++; if (gnt !== 4'b0001 || gnt_idx !== 2'b11)
      begin n_bad++; $display("FAIL wrap_owner3: gnt=%b idx=%b want 0001/11", gnt, gnt_idx); end
    req = 4'b1000;
    repeat (3) step();
    n_cmp++; if (gnt !== 4'b1000 || gnt_idx !== 2'b00 || gnt_valid !== 1'b1)
      begin n_bad++; $display("FAIL wrap_next: gnt=%b idx=%b valid=%b want 1000/00/1", gnt, gnt_idx, gnt_valid); end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b1000;
    step();
    n_cmp++; if (gnt !== 4'b1000)
      begin n_bad++; $display("FAIL midrst_pre: gnt=%b want 1000", gnt); end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || busy !== 1'b0)
      begin n_bad++; $display("FAIL midrst_drop: gnt=%b valid=%b busy=%b want 0000/0/0", gnt, gnt_valid, busy); end
    #2;
    req   = 4'b0101;
    rst_n = 1'b1;
    step();
    n_cmp++; if (gnt !== 4'b0100 || gnt_idx !== 2'b01 || gnt_valid !== 1'b1)
      begin n_bad++; $display("FAIL midrst_regrant: gnt=%b idx=%b valid=%b want 0100/01/1", gnt, gnt_idx, gnt_valid); end
  endtask

  task automatic test_hold();
    do_reset();
    req = 4'b1001;
    step();
`ifdef ARB_PREEMPT_EN
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (gnt !== 4'b1000 || gnt_valid !== 1'b1)
        begin n_bad++; $display("FAIL preempt_hold c=%0d: gnt=%b valid=%b want 1000/1", c, gnt, gnt_valid); end
      step();
    end
    n_cmp++; if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || busy !== 1'b1)
      begin n_bad++; $display("FAIL preempt_release: gnt=%b valid=%b busy=%b want 0000/0/1", gnt, gnt_valid, busy); end
    repeat (2) step();
    n_cmp++; if (gnt !== 4'b0001 || gnt_idx !== 2'b11)
      begin n_bad++; $display("FAIL preempt_next: gnt=%b idx=%b want 0001/11", gnt, gnt_idx); end
`else
    for (int c = 0; c < 55; c++) begin
      n_cmp++; if (gnt !== 4'b1000 || gnt_valid !== 1'b1)
        begin n_bad++; $display("FAIL nopreempt_hold c=%0d: gnt=%b valid=%b want 1000/1", c, gnt, gnt_valid); end
      step();
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_reset_mid_grant();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
